// File: rtl/i2d_core_defines.sv
// rtl/i2d_core_defines.sv - shared i2d core types and constants
package i2d_core_defines;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] instr_t;
  typedef logic [5:0]  opcode_t;

  localparam opcode_t OPCODE_NOP = 6'h3F;
  localparam addr_t   INSTR_STEP = 32'd4;

  // One fetched word together with where it came from and whether the bus faulted
  typedef struct packed {
    addr_t  pc;
    instr_t instr;
    logic   err;
  } if_entry_t;

  function automatic instr_t nop_instr();
    return {OPCODE_NOP, 26'(0)};
  endfunction

endpackage

// File: rtl/wishbone.sv
// rtl/wishbone.sv - pipelined Wishbone read port bundle
interface wishbone;

  logic [31:0] adr;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic        stall;
  logic        ack;
  logic        err;
  logic [31:0] dat_so;

  modport pl_master (
    output adr, cyc, stb, we, sel,
    input  stall, ack, err, dat_so
  );

  modport pl_slave (
    input  adr, cyc, stb, we, sel,
    output stall, ack, err, dat_so
  );

endinterface

// File: rtl/core_if_fifo.sv
// rtl/core_if_fifo.sv - DEPTH-deep prefetch FIFO of fetched entries
module core_if_fifo
  import i2d_core_defines::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  if_entry_t              wr_entry,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output if_entry_t              head
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra bit so equal indices can be told apart as full or empty
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  if_entry_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // Status, head view and qualified push/pop; flush overrides both
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count   = wr_ptr - rd_ptr;
    do_pop  = pop && !flush && !empty;
    do_push = push && !flush && (!full || do_pop);
    head    = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; a push at full is only taken together with a pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

endmodule

// File: rtl/core_if_pf.sv
// rtl/core_if_pf.sv - prefetching instruction-fetch stage
module core_if_pf
  import i2d_core_defines::*;
#(
  parameter int    DEPTH           = 4,
  parameter int    MAX_OUTSTANDING = 2,
  parameter addr_t RESET_PC        = 32'h0
) (
  input  logic       clk,
  input  logic       rst,
  wishbone.pl_master bus,
  input  logic       if_halt,
  input  logic       set_pc,
  input  addr_t      new_pc,
  input  logic       id_ready,
  output logic       if_valid,
  output addr_t      if_pc,
  output instr_t     if_instr,
  output logic       if_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(DEPTH) + 1;

  addr_t          fpc;
  addr_t          rpc;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  inflight_nxt;
  logic [CW-1:0]  discard;
  logic           err_lock;

  logic           stb;
  logic           accept;
  logic           resp;
  logic           below_max;
  logic           slot_free;

  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [PW-1:0]  fifo_count;
  if_entry_t      fifo_head;
  if_entry_t      push_entry;

  // Offer a request only when its response already has a reserved FIFO slot
  always_comb begin
    below_max = 32'(inflight) < MAX_OUTSTANDING;
    slot_free = (32'(fifo_count) + 32'(inflight)) < DEPTH;
    stb       = rst && !if_halt && !set_pc && !err_lock && below_max && slot_free;
    accept    = stb && !bus.stall;
    resp      = bus.ack || bus.err;
  end

  // Outstanding count; an accept and a response in the same cycle cancel out
  always_comb begin
    inflight_nxt = inflight;
    if (accept && !resp) begin
      inflight_nxt = inflight + CW'(1);
    end else if (!accept && resp && inflight != '0) begin
      inflight_nxt = inflight - CW'(1);
    end
  end

  assign bus.stb = stb;
  assign bus.cyc = stb || (inflight != '0);
  assign bus.we  = 1'b0;
  assign bus.sel = 4'b1111;
  assign bus.adr = fpc;

  // Responses owed to pre-redirect requests, or arriving with a redirect, are dropped
  always_comb begin
    fifo_pop   = if_valid && id_ready && !set_pc;
    fifo_push  = resp && (discard == '0) && !set_pc && (!fifo_full || fifo_pop);
    push_entry = '{pc: rpc, instr: bus.dat_so, err: bus.err};
  end

  // Fetch address, response address, request accounting and error lock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      err_lock <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      if (set_pc) begin
        fpc      <= new_pc;
        rpc      <= new_pc;
        err_lock <= 1'b0;
        discard  <= inflight_nxt;
      end else begin
        if (accept)                 fpc      <= fpc + INSTR_STEP;
        if (fifo_push)              rpc      <= rpc + INSTR_STEP;
        if (resp && discard != '0)  discard  <= discard - CW'(1);
        if (fifo_push && bus.err)   err_lock <= 1'b1;
      end
    end
  end

  core_if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (set_pc),
    .wr_entry (push_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  // Decode-side view; NOP and zeroes whenever nothing is presented
  always_comb begin
    if_valid = !fifo_empty && !if_halt;
    if_pc    = '0;
    if_instr = nop_instr();
    if_err   = 1'b0;
    if (if_valid) begin
      if_pc    = fifo_head.pc;
      if_instr = fifo_head.instr;
      if_err   = fifo_head.err;
    end
  end

endmodule

// File: tb/tb_core_if_pf.sv
// tb/tb_core_if_pf.sv - scoreboard bench for core_if_pf
module tb_core_if_pf;
  import i2d_core_defines::*;

  localparam logic [31:0] NOP_WORD = 32'hFC00_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_halt = 1'b0;
  logic        set_pc = 1'b0;
  logic [31:0] new_pc = '0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_err;

  wishbone bus_if();

  core_if_pf #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .if_halt  (if_halt),
    .set_pc   (set_pc),
    .new_pc   (new_pc),
    .id_ready (id_ready),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .if_err   (if_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  int          lat = 1;
  int          tick = 0;
  int          req_cnt = 0;
  logic [31:0] req_log[$];
  logic [31:0] pend_adr[$];
  int          pend_due[$];
  logic        err_en = 1'b0;
  logic [31:0] err_adr = '0;
  logic        acc_now;
  logic [31:0] acc_adr;
  logic [31:0] rsp_adr;
  int          base;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic redirect(input logic [31:0] a);
    set_pc = 1'b1;
    new_pc = a;
    step();
    set_pc = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic err);
    exp_q.push_back({pc, 32'hC000_0000 | pc, err});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_drain: %0d entries left, want 0", name, exp_q.size());
      exp_q.delete();
    end
    id_ready = 1'b0;
  endtask

  // Monitor: every handshake pops the scoreboard, idle cycles must show NOP
  always @(negedge clk) begin
    if (rst && !set_pc) begin
      if (if_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pop: got pc %h want no entry", if_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pop_entry", {if_pc, if_instr, if_err}, mon_e);
        end
      end else if (!if_valid) begin
        chk("idle_out", {if_pc, if_instr, if_err}, {32'h0, NOP_WORD, 1'b0});
      end
    end
  end

  // Pipelined slave: accepts on stb&&!stall, answers in order after lat cycles
  initial begin : slave
    bus_if.ack    = 1'b0;
    bus_if.err    = 1'b0;
    bus_if.dat_so = '0;
    forever begin
      @(negedge clk);
      acc_now = rst && bus_if.cyc && bus_if.stb && !bus_if.stall;
      acc_adr = bus_if.adr;
      @(posedge clk);
      #1;
      tick++;
      bus_if.ack    = 1'b0;
      bus_if.err    = 1'b0;
      bus_if.dat_so = '0;
      if (!rst) begin
        pend_adr.delete();
        pend_due.delete();
      end else begin
        if (acc_now) begin
          pend_adr.push_back(acc_adr);
          pend_due.push_back(tick + lat - 1);
          req_cnt++;
          req_log.push_back(acc_adr);
        end
        if (pend_adr.size() > 0 && pend_due[0] <= tick) begin
          rsp_adr = pend_adr.pop_front();
          void'(pend_due.pop_front());
          bus_if.dat_so = 32'hC000_0000 | rsp_adr;
          if (err_en && rsp_adr == err_adr) bus_if.err = 1'b1;
          else                               bus_if.ack = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time exhausted, want finish");
    $fatal(1);
  end

  initial begin : stim
    bus_if.stall = 1'b0;
    steps(2);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, NOP_WORD);
    chk("rst_err", if_err, 1'b0);
    chk("rst_cyc", bus_if.cyc, 1'b0);
    chk("rst_stb", bus_if.stb, 1'b0);
    chk("bus_we", bus_if.we, 1'b0);
    chk("bus_sel", bus_if.sel, 4'hF);

    // Sustained zero-wait fetch from RESET_PC
    for (int i = 0; i < 8; i++) push_exp(32'h0 + 32'(4 * i), 1'b0);
    req_log.delete();
    id_ready = 1'b1;
    rst = 1'b1;
    step();
    chk("t1_valid_early", if_valid, 1'b0);
    chk("t1_first_ack", bus_if.ack, 1'b1);
    step();
    chk("t1_first_valid", if_valid, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t1_sustained", if_valid, 1'b1);
    end
    drain("t1");
    chk("t1_req_seen", req_log.size() >= 4, 1'b1);
    if (req_log.size() >= 4) begin
      chk("t1_req0", req_log[0], 32'h0);
      chk("t1_req1", req_log[1], 32'h4);
      chk("t1_req2", req_log[2], 32'h8);
      chk("t1_req3", req_log[3], 32'hC);
    end

    // Back-pressure: stall holds the request, then exactly DEPTH issues
    steps(10);
    bus_if.stall = 1'b1;
    base = req_cnt;
    redirect(32'h200);
    steps(3);
    chk("t2_stall_stb", bus_if.stb, 1'b1);
    chk("t2_stall_adr", bus_if.adr, 32'h200);
    chk("t2_stall_noacc", req_cnt - base, 0);
    bus_if.stall = 1'b0;
    steps(15);
    chk("t2_issued", req_cnt - base, 4);
    chk("t2_full_stb", bus_if.stb, 1'b0);
    chk("t2_full_cyc", bus_if.cyc, 1'b0);
    for (int i = 0; i < 8; i++) push_exp(32'h200 + 32'(4 * i), 1'b0);
    id_ready = 1'b1;
    drain("t2");

    // Redirect with two requests in flight at latency 3
    steps(10);
    lat = 3;
    redirect(32'h40);
    step();
    step();
    chk("t3_stb_at_max", bus_if.stb, 1'b0);
    chk("t3_cyc_at_max", bus_if.cyc, 1'b1);
    redirect(32'h100);
    for (int i = 0; i < 4; i++) push_exp(32'h100 + 32'(4 * i), 1'b0);
    id_ready = 1'b1;
    drain("t3");

    // Bus error on 0x8 locks issue until the next redirect
    steps(10);
    lat = 1;
    err_en = 1'b1;
    err_adr = 32'h8;
    redirect(32'h0);
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    push_exp(32'h8, 1'b1);
    push_exp(32'hC, 1'b0);
    id_ready = 1'b1;
    drain("t4");
    base = req_cnt;
    steps(8);
    chk("t4_locked_req", req_cnt - base, 0);
    chk("t4_locked_stb", bus_if.stb, 1'b0);
    chk("t4_locked_cyc", bus_if.cyc, 1'b0);
    redirect(32'h20);
    push_exp(32'h20, 1'b0);
    push_exp(32'h24, 1'b0);
    push_exp(32'h28, 1'b0);
    id_ready = 1'b1;
    drain("t4b");
    err_en = 1'b0;

    // Halt with one outstanding request
    steps(10);
    lat = 3;
    redirect(32'h300);
    step();
    if_halt = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_halt_valid", if_valid, 1'b0);
      chk("t5_halt_instr", if_instr, NOP_WORD);
      chk("t5_halt_stb", bus_if.stb, 1'b0);
    end
    chk("t5_halt_drained", bus_if.cyc, 1'b0);
    push_exp(32'h300, 1'b0);
    push_exp(32'h304, 1'b0);
    push_exp(32'h308, 1'b0);
    if_halt = 1'b0;
    drain("t5");

    // Reset in the middle of a burst
    steps(10);
    lat = 1;
    redirect(32'h400);
    steps(2);
    rst = 1'b0;
    #1;
    chk("t6_rst_cyc", bus_if.cyc, 1'b0);
    chk("t6_rst_stb", bus_if.stb, 1'b0);
    chk("t6_rst_valid", if_valid, 1'b0);
    chk("t6_rst_instr", if_instr, NOP_WORD);
    steps(2);
    for (int i = 0; i < 4; i++) push_exp(32'h0 + 32'(4 * i), 1'b0);
    id_ready = 1'b1;
    rst = 1'b1;
    drain("t6");

    steps(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
